// File: rtl/priority_decoder_3to8_seq_if.sv
// Request/strobe link between the priority encoder and the 3-to-8 strobe decoder.
// The master side drives the encoded request; the slave side returns strobe and status.
interface priority_decoder_3to8_seq_if;
    logic [2:0] in;
    logic       valid;
    logic [7:0] out;
    logic       out_valid;
    logic [7:0] pending;
    logic       busy;
    logic       overflow;

    modport master (
        output in,
        output valid,
        input  out,
        input  out_valid,
        input  pending,
        input  busy,
        input  overflow
    );

    modport slave (
        input  in,
        input  valid,
        output out,
        output out_valid,
        output pending,
        output busy,
        output overflow
    );
endinterface

// File: rtl/priority_decoder_3to8_seq.sv
// Receive side of the priority-encoded request link: decodes a 3-bit index into a timed
// one-hot strobe, queueing requests that arrive while busy and serving the highest index first.
module priority_decoder_3to8_seq #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    priority_decoder_3to8_seq_if.slave    bus
);

    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic [7:0]    pending_r;
    logic [7:0]    pending_nxt_s;
    logic [7:0]    out_r;
    logic [7:0]    out_nxt_s;
    logic          out_valid_r;
    logic          out_valid_nxt_s;
    logic          overflow_r;
    logic          overflow_nxt_s;
    logic          busy_r;
    logic          busy_nxt_s;
    logic          launch_s;
    logic [2:0]    launch_idx_s;
    logic [7:0]    launch_mask_s;
    logic [7:0]    set_mask_s;
    logic [7:0]    clear_mask_s;

    // Index of the most significant set bit; same priority order as the encoder.
    function automatic logic [2:0] highest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // State, counter and pending bitmap registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            pending_r <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            pending_r <= pending_nxt_s;
        end
    end

    // Next-state logic: strobe phase, gap phase and launch decision.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        launch_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (pending_r != 8'd0) begin
                    launch_s    = 1'b1;
                    state_nxt_s = ACTIVE;
                    cnt_nxt_s   = CW'(PULSE_LEN - 1);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACTIVE: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_nxt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    state_nxt_s = GAP;
                    cnt_nxt_s   = CW'(GAP_LEN - 1);
                end
            end
            GAP: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_nxt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end else if (pending_r != 8'd0) begin
                    launch_s    = 1'b1;
                    state_nxt_s = ACTIVE;
                    cnt_nxt_s   = CW'(PULSE_LEN - 1);
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CW{1'b0}};
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Output/datapath logic. A request landing on the bit being launched is re-queued
    // rather than flagged, so set wins over clear without raising overflow.
    always_comb begin
        launch_idx_s  = highest_idx(pending_r);
        launch_mask_s = 8'd1 << launch_idx_s;
        if (launch_s) begin
            clear_mask_s = launch_mask_s;
        end else begin
            clear_mask_s = 8'd0;
        end
        if (bus.valid) begin
            set_mask_s = 8'd1 << bus.in;
        end else begin
            set_mask_s = 8'd0;
        end
        pending_nxt_s  = (pending_r & ~clear_mask_s) | set_mask_s;
        overflow_nxt_s = |(set_mask_s & pending_r & ~clear_mask_s);
        if (launch_s) begin
            out_nxt_s = launch_mask_s;
        end else if (state_nxt_s == ACTIVE) begin
            out_nxt_s = out_r;
        end else begin
            out_nxt_s = 8'd0;
        end
        out_valid_nxt_s = (state_nxt_s == ACTIVE);
        busy_nxt_s      = (state_nxt_s != IDLE);
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_r       <= 8'd0;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_r       <= out_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            overflow_r  <= overflow_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.pending   = pending_r;
    assign bus.busy      = busy_r;
    assign bus.overflow  = overflow_r;

endmodule
